sc_prbs_checker: RTL and testbench

//  Receive-side partner of the shift-register pseudo-random word generator. Checks a stream
//  of parallel PRBS words against a local LFSR predictor. Self-synchronises to the incoming

---
 rtl/sc_prbs_pkg.sv | 19 +
 rtl/sc_prbs_step.sv | 16 +
 rtl/sc_prbs_checker.sv | 195 +++++++++++++++++++
 tb/tb_sc_prbs_checker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_prbs_pkg.sv
// Shared PRBS definitions: state encodings, default polynomial and the
// Galois LFSR step, used by both the generator and checker ends.
package sc_prbs_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

    // x^8 + x^4 + x^3 + x^2 + 1
    localparam logic [7:0] PRBS_DEFAULT_POLY = 8'h1D;

    // One Galois step for the default 8-bit word.
    function automatic logic [7:0] prbs_step8(input logic [7:0] w, input logic [7:0] poly);
        return {w[6:0], 1'b0} ^ (w[7] ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/sc_prbs_step.sv
// Combinational W-bit Galois LFSR step. The generator instances the same
// block, so both ends of the link share one polynomial definition.
module sc_prbs_step #(
    parameter int                 W    = 8,
    parameter logic [W-1:0]       POLY = W'(8'h1D)
) (
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    // Shift left, fold the outgoing MSB back in through the feedback mask.
    always_comb begin
        data_o = {data_i[W-2:0], 1'b0} ^ (data_i[W-1] ? POLY : '0);
    end

endmodule

// File: rtl/sc_prbs_checker.sv
// PRBS word checker: self-synchronising LFSR predictor with lock/loss
// detection and a saturating word-error counter.
// Optional build macro PRBSCHECK_BITCOUNT_EN adds a saturating bit-error
// accumulator port (SC_PRBSCHECK_biterr_OutBUS).
//
//   state  | meaning
//   SEARCH | waiting for a non-zero word to seed the predictor
//   VERIFY | seeded; counting consecutive correct predictions
//   LOCKED | predictor free-runs; mismatches counted as errors
module sc_prbs_checker
    import sc_prbs_pkg::*;
#(
    parameter int                               PRBSCHECK_DATAWIDTH = 8,
    parameter logic [PRBSCHECK_DATAWIDTH-1:0]   PRBSCHECK_POLY      = PRBSCHECK_DATAWIDTH'(PRBS_DEFAULT_POLY),
    parameter int                               PRBSCHECK_LOCKCNT   = 4,
    parameter int                               PRBSCHECK_LOSSCNT   = 3,
    parameter int                               PRBSCHECK_ERRWIDTH  = 16
) (
    input  logic                            SC_PRBSCHECK_CLOCK_50,
    input  logic                            SC_PRBSCHECK_RESET_InHigh,
    input  logic                            SC_PRBSCHECK_clear_InHigh,
    input  logic                            SC_PRBSCHECK_valid_InHigh,
    input  logic [PRBSCHECK_DATAWIDTH-1:0]  SC_PRBSCHECK_data_InBUS,
    output logic                            SC_PRBSCHECK_locked_OutHigh,
    output logic                            SC_PRBSCHECK_error_OutHigh,
    output logic [PRBSCHECK_DATAWIDTH-1:0]  SC_PRBSCHECK_expected_OutBUS,
    output logic [PRBSCHECK_ERRWIDTH-1:0]   SC_PRBSCHECK_errcnt_OutBUS
`ifdef PRBSCHECK_BITCOUNT_EN
    ,
    output logic [PRBSCHECK_ERRWIDTH-1:0]   SC_PRBSCHECK_biterr_OutBUS
`endif
);

    localparam int W = PRBSCHECK_DATAWIDTH;
    localparam int E = PRBSCHECK_ERRWIDTH;

    prbs_state_e    state_q, state_d;
    logic [W-1:0]   exp_q, exp_d;
    logic [3:0]     good_q, good_d;
    logic [3:0]     bad_q, bad_d;
    logic           locked_q, locked_d;
    logic           err_q, err_d;
    logic [E-1:0]   errcnt_q, errcnt_d;
    logic [W-1:0]   step_in, step_out;
    logic [4:0]     good_inc, bad_inc;
    logic           match;

    // Locked: the predictor advances from itself so bit errors can't derail it.
    // Otherwise it reseeds from the received word.
    assign step_in  = (state_q == LOCKED) ? exp_q : SC_PRBSCHECK_data_InBUS;
    assign match    = (SC_PRBSCHECK_data_InBUS == exp_q);
    assign good_inc = {1'b0, good_q} + 5'd1;
    assign bad_inc  = {1'b0, bad_q} + 5'd1;

    sc_prbs_step #(
        .W    (W),
        .POLY (PRBSCHECK_POLY)
    ) u_step (
        .data_i (step_in),
        .data_o (step_out)
    );

`ifdef PRBSCHECK_BITCOUNT_EN
    logic [E-1:0]   biterr_q, biterr_d;
    logic [W-1:0]   diff;
    logic [E:0]     pop;
    logic [E:0]     bit_sum;

    // Bits in error for the current word, summed with saturation.
    always_comb begin
        diff = SC_PRBSCHECK_data_InBUS ^ exp_q;
        pop  = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + (E+1)'(diff[i]);
        end
        bit_sum = {1'b0, biterr_q} + pop;
    end
`endif

    // Next-state, predictor, counters and registered outputs.
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        good_d   = good_q;
        bad_d    = bad_q;
        err_d    = 1'b0;
        errcnt_d = errcnt_q;
`ifdef PRBSCHECK_BITCOUNT_EN
        biterr_d = biterr_q;
`endif
        if (SC_PRBSCHECK_valid_InHigh) begin
            case (state_q)
                SEARCH: begin
                    // An all-zero word is the LFSR lock-up state; it can't seed.
                    if (SC_PRBSCHECK_data_InBUS != '0) begin
                        exp_d  = step_out;
                        good_d = 4'd1;
                        if (PRBSCHECK_LOCKCNT == 1) begin
                            state_d = LOCKED;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (match) begin
                        exp_d  = step_out;
                        good_d = good_inc[3:0];
                        if (good_inc >= 5'(PRBSCHECK_LOCKCNT)) begin
                            state_d = LOCKED;
                        end
                    end else if (SC_PRBSCHECK_data_InBUS == '0) begin
                        state_d = SEARCH;
                        good_d  = 4'd0;
                    end else begin
                        exp_d  = step_out;
                        good_d = 4'd1;
                    end
                end
                LOCKED: begin
                    exp_d = step_out;
                    if (match) begin
                        bad_d = 4'd0;
                    end else begin
                        err_d = 1'b1;
                        if (errcnt_q != '1) begin
                            errcnt_d = errcnt_q + E'(1);
                        end
`ifdef PRBSCHECK_BITCOUNT_EN
                        biterr_d = bit_sum[E] ? '1 : bit_sum[E-1:0];
`endif
                        if (bad_inc >= 5'(PRBSCHECK_LOSSCNT)) begin
                            state_d = SEARCH;
                            bad_d   = 4'd0;
                            good_d  = 4'd0;
                        end else begin
                            bad_d = bad_inc[3:0];
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
        // Clear only touches the counters and takes priority over an increment.
        if (SC_PRBSCHECK_clear_InHigh) begin
            errcnt_d = '0;
`ifdef PRBSCHECK_BITCOUNT_EN
            biterr_d = '0;
`endif
        end
        locked_d = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge SC_PRBSCHECK_CLOCK_50 or posedge SC_PRBSCHECK_RESET_InHigh) begin
        if (SC_PRBSCHECK_RESET_InHigh) begin
            state_q  <= SEARCH;
            exp_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

`ifdef PRBSCHECK_BITCOUNT_EN
    // Bit-error accumulator register.
    always_ff @(posedge SC_PRBSCHECK_CLOCK_50 or posedge SC_PRBSCHECK_RESET_InHigh) begin
        if (SC_PRBSCHECK_RESET_InHigh) begin
            biterr_q <= '0;
        end else begin
            biterr_q <= biterr_d;
        end
    end

    assign SC_PRBSCHECK_biterr_OutBUS = biterr_q;
`endif

    assign SC_PRBSCHECK_locked_OutHigh  = locked_q;
    assign SC_PRBSCHECK_error_OutHigh   = err_q;
    assign SC_PRBSCHECK_expected_OutBUS = exp_q;
    assign SC_PRBSCHECK_errcnt_OutBUS   = errcnt_q;

endmodule

// File: tb/tb_sc_prbs_checker.sv
// Directed bench for sc_prbs_checker (W=8, POLY=1D, LOCKCNT=4, LOSSCNT=3,
// ERRWIDTH=4 so saturation is reachable quickly).
module tb_sc_prbs_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       vld;
    logic [7:0] dat;
    logic       locked;
    logic       err;
    logic [7:0] expct;
    logic [3:0] errcnt;
`ifdef PRBSCHECK_BITCOUNT_EN
    logic [3:0] biterr;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] e;

    sc_prbs_checker #(
        .PRBSCHECK_DATAWIDTH (8),
        .PRBSCHECK_POLY      (8'h1D),
        .PRBSCHECK_LOCKCNT   (4),
        .PRBSCHECK_LOSSCNT   (3),
        .PRBSCHECK_ERRWIDTH  (4)
    ) dut (
        .SC_PRBSCHECK_CLOCK_50        (clk),
        .SC_PRBSCHECK_RESET_InHigh    (rst),
        .SC_PRBSCHECK_clear_InHigh    (clr),
        .SC_PRBSCHECK_valid_InHigh    (vld),
        .SC_PRBSCHECK_data_InBUS      (dat),
        .SC_PRBSCHECK_locked_OutHigh  (locked),
        .SC_PRBSCHECK_error_OutHigh   (err),
        .SC_PRBSCHECK_expected_OutBUS (expct),
        .SC_PRBSCHECK_errcnt_OutBUS   (errcnt)
`ifdef PRBSCHECK_BITCOUNT_EN
        ,
        .SC_PRBSCHECK_biterr_OutBUS   (biterr)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, expv);
        end
    endtask

    // Independent reference step for the free-running phase.
    function automatic logic [7:0] nxt(input logic [7:0] w);
        return {w[6:0], 1'b0} ^ (w[7] ? 8'h1D : 8'h00);
    endfunction

    // Called at a negedge; presents one valid word, returns at the next negedge.
    task automatic send(input logic [7:0] d);
        vld = 1'b1;
        dat = d;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; vld = 1'b0; dat = 8'h00;
        @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_error", err, 0);
        chk("rst_expected", expct, 8'h00);
        chk("rst_errcnt", errcnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: acquire lock on 01,02,04,08,10
        send(8'h01);
        chk("seed_expected", expct, 8'h02);
        chk("seed_unlocked", locked, 0);
        send(8'h02);
        send(8'h04);
        chk("verify_unlocked", locked, 0);
        send(8'h08);
        send(8'h10);
        chk("t1_locked", locked, 1);
        chk("t1_expected", expct, 8'h20);
        chk("t1_errcnt", errcnt, 0);

        // 2: single bad word while locked
        send(8'h20);
        send(8'h40);
        chk("t2_noerr", err, 0);
        send(8'h81);
        chk("t2_err_pulse", err, 1);
        chk("t2_errcnt", errcnt, 1);
        send(8'h1D);
        chk("t2_pulse_end", err, 0);
        send(8'h3A);
        chk("t2_locked", locked, 1);
        chk("t2_expected", expct, 8'h74);
        chk("t2_errcnt_hold", errcnt, 1);

        // 3: three consecutive bad words drop lock
        send(8'hFF);
        send(8'hFF);
        chk("t3_still_locked", locked, 1);
        chk("t3_errcnt2", errcnt, 3);
        send(8'hFF);
        chk("t3_err", err, 1);
        chk("t3_errcnt", errcnt, 4);
        chk("t3_unlocked", locked, 0);
        chk("t3_expected", expct, 8'h87);

        // 4: resync with zero words and valid gaps
        idle();
        send(8'h00);
        chk("t4_zero_ignored", expct, 8'h87);
        idle();
        send(8'h00);
        idle();
        send(8'h80);
        chk("t4_seed_expected", expct, 8'h1D);
        idle();
        send(8'h1D);
        idle();
        send(8'h3A);
        idle();
        chk("t4_gap_expected", expct, 8'h74);
        chk("t4_gap_noerr", err, 0);
        chk("t4_gap_unlocked", locked, 0);
        send(8'h74);
        chk("t4_locked", locked, 1);
        chk("t4_expected", expct, 8'hE8);
        chk("t4_errcnt", errcnt, 4);

        // 5: saturation, then clear colliding with a mismatch
        e = 8'hE8;
        for (int i = 0; i < 11; i++) begin
            send(e ^ 8'h01);
            e = nxt(e);
            send(e);
            e = nxt(e);
        end
        chk("t5_at_sat", errcnt, 4'hF);
        for (int i = 0; i < 2; i++) begin
            send(e ^ 8'h01);
            e = nxt(e);
            send(e);
            e = nxt(e);
        end
        chk("t5_sat_hold", errcnt, 4'hF);
        chk("t5_locked", locked, 1);
        chk("t5_expected", expct, e);
        clr = 1'b1;
        send(e ^ 8'h0F);
        clr = 1'b0;
        e = nxt(e);
        chk("t5_clear_wins", errcnt, 0);
        chk("t5_clear_err", err, 1);
`ifdef PRBSCHECK_BITCOUNT_EN
        chk("t5_biterr_clear", biterr, 0);
`endif
        send(e ^ 8'h0F);
        e = nxt(e);
        chk("t5_after_clear", errcnt, 1);
        chk("t5_still_locked", locked, 1);
`ifdef PRBSCHECK_BITCOUNT_EN
        chk("t5_biterr4", biterr, 4);
`endif
        send(e);
        chk("t5_good_after", err, 0);

        // 6: async reset mid-LOCKED, checked before the next rising edge
        #3;
        rst = 1'b1;
        #1;
        chk("t6_locked", locked, 0);
        chk("t6_errcnt", errcnt, 0);
        chk("t6_expected", expct, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h01);
        send(8'h02);
        send(8'h04);
        chk("t6_resync_unlocked", locked, 0);
        send(8'h08);
        send(8'h10);
        chk("t6_relocked", locked, 1);
        chk("t6_expected_after", expct, 8'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
